hazard_ctrl: RTL

Pipeline hazard controller for the five-stage MIPS datapath. Each cycle it compares the register reads of the D-stage instruction against the destinations and Tnew values of the E and M stages. It also tracks a multi-cycle multiply/divide unit with an internal busy counter. From these it drives the freeze and bubble controls: `stall_PC`, `stall_FD` and `clr_DE`. Forwarding selects are produced elsewhere; this block only decides when forwarding cannot cover a dependency.

---
 rtl/hazard_ctrl.sv | 79 +++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decides when the D-stage instruction must be held
// because forwarding cannot cover a dependency or the multiply/divide unit is busy.
module hazard_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  tuse_rs_D,
   input  logic [1:0]  tuse_rt_D,
   input  logic        md_D,
   input  logic [4:0]  A3_E,
   input  logic [1:0]  tnew_E,
   input  logic [4:0]  A3_M,
   input  logic [1:0]  tnew_M,
   input  logic        md_start_E,
   input  logic        md_div_E,
   output logic        stall_PC,
   output logic        stall_FD,
   output logic        clr_DE,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cycles
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic             hz_rs;
   logic             hz_rt;
   logic             hz_md;
   logic             stall;

   // A source only stalls when its result arrives later than the consumer needs it;
   // tuse = 3 can never be exceeded by a 2-bit tnew, so unused operands never stall.
   always_comb begin
      hz_rs = (rs_D != 5'd0) &&
              (((rs_D == A3_E) && (tnew_E > tuse_rs_D)) ||
               ((rs_D == A3_M) && (tnew_M > tuse_rs_D)));
      hz_rt = (rt_D != 5'd0) &&
              (((rt_D == A3_E) && (tnew_E > tuse_rt_D)) ||
               ((rt_D == A3_M) && (tnew_M > tuse_rt_D)));
      hz_md = md_D && (md_busy || md_start_E);
      stall = (hz_rs || hz_rt || hz_md) && !reset;
   end

   assign stall_PC = stall;
   assign stall_FD = stall;
   assign clr_DE   = stall;
   assign md_busy  = (cnt != '0);

   // A start while already counting cannot come from a correctly stalled pipeline; it is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         md_done <= 1'b0;
      end else begin
         md_done <= (cnt == CNT_ONE);
         if (md_start_E && (cnt == '0))
            cnt <= md_div_E ? DIV_LOAD : MULT_LOAD;
         else if (cnt != '0)
            cnt <= cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cycles <= 32'd0;
      else if (stall)
         stall_cycles <= stall_cycles + 32'd1;
   end

endmodule
